// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// illegal_op exists only when MCTRL_ILLEGAL_TRAP_EN is defined.
interface multi_cycle_ctrl_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [5:0]            OPcode;
  logic [5:0]            Fun;
  logic                  MIO_ready;
  logic                  PCWrite;
  logic                  PCWriteCond;
  logic                  Branch_ne;
  logic                  IorD;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  CPU_MIO;
  logic                  MemtoReg;
  logic                  RegDst;
  logic                  RegWrite;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic                  ExtZero;
  logic [1:0]            PCSource;
  logic [ALU_CTRL_W-1:0] ALU_Control;
  logic                  bus_err;
  logic [3:0]            state;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic                  illegal_op;
`endif

  modport master (
`ifdef MCTRL_ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    input  OPcode, Fun, MIO_ready,
    output PCWrite, PCWriteCond, Branch_ne,
    output IorD, MemRead, MemWrite, IRWrite,
    output CPU_MIO, MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, ExtZero, PCSource,
    output ALU_Control, bus_err, state
  );

  modport slave (
`ifdef MCTRL_ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    output OPcode, Fun, MIO_ready,
    input  PCWrite, PCWriteCond, Branch_ne,
    input  IorD, MemRead, MemWrite, IRWrite,
    input  CPU_MIO, MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, ExtZero, PCSource,
    input  ALU_Control, bus_err, state
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory-wait timeout.
// Optional MCTRL_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP until reset.
module multi_cycle_ctrl #(
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  multi_cycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MA   = 4'd2,
    S_MR   = 4'd3,
    S_LWB  = 4'd4,
    S_MW   = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_J    = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11,
    S_TRAP = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;
  localparam logic [2:0] A_NOR = 3'b100;
  localparam logic [2:0] A_XOR = 3'b011;
  localparam logic [2:0] A_SRL = 3'b101;

  // Last tolerated wait cycle: the cycle on which the wait count
  // would reach MEM_TIMEOUT aborts the access.
  localparam logic [TMO_W-1:0] TMO_LAST =
    (MEM_TIMEOUT == 0) ? '0 : TMO_W'(MEM_TIMEOUT - 1);

  state_e           r_state;
  logic [TMO_W-1:0] r_cnt;
  logic             r_bus_err;

  logic             w_ready;
  logic             w_mem_st;
  logic             w_tmo;
  logic [TMO_W-1:0] w_cnt_inc;
  logic             w_op_r;
  logic             w_op_mem;
  logic             w_op_br;
  logic             w_op_j;
  logic             w_op_i;
  logic [2:0]       w_alu;

  assign w_ready   = bus.MIO_ready;
  assign w_mem_st  = (r_state == S_IF) || (r_state == S_MR)
                  || (r_state == S_MW);
  assign w_tmo     = (MEM_TIMEOUT != 0) && w_mem_st && !w_ready
                  && (r_cnt == TMO_LAST);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  assign w_op_r   = (bus.OPcode == OP_R);
  assign w_op_mem = (bus.OPcode == OP_LW) || (bus.OPcode == OP_SW);
  assign w_op_br  = (bus.OPcode == OP_BEQ) || (bus.OPcode == OP_BNE);
  assign w_op_j   = (bus.OPcode == OP_J);
  assign w_op_i   = (bus.OPcode == OP_ADDI) || (bus.OPcode == OP_SLTI)
                 || (bus.OPcode == OP_ANDI) || (bus.OPcode == OP_ORI);

  // State sequencing, wait counter and sticky bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IF;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else if (w_tmo) begin
      r_state   <= S_IF;
      r_cnt     <= '0;
      r_bus_err <= 1'b1;
    end else begin
      r_cnt <= '0;
      unique case (r_state)
        S_IF: begin
          if (w_ready) r_state <= S_ID;
          else         r_cnt   <= w_cnt_inc;
        end
        S_ID: begin
          unique case (1'b1)
            w_op_r:   r_state <= S_REX;
            w_op_mem: r_state <= S_MA;
            w_op_br:  r_state <= S_BR;
            w_op_j:   r_state <= S_J;
            w_op_i:   r_state <= S_IEX;
`ifdef MCTRL_ILLEGAL_TRAP_EN
            default:  r_state <= S_TRAP;
`else
            default:  r_state <= S_IF;
`endif
          endcase
        end
        S_MA: r_state <= (bus.OPcode == OP_SW) ? S_MW : S_MR;
        S_MR: begin
          if (w_ready) r_state <= S_LWB;
          else         r_cnt   <= w_cnt_inc;
        end
        S_MW: begin
          if (w_ready) r_state <= S_IF;
          else         r_cnt   <= w_cnt_inc;
        end
        S_REX:  r_state <= S_RWB;
        S_IEX:  r_state <= S_IWB;
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_IF;
      endcase
    end
  end

  // Moore decode of the datapath controls; everything low during reset.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.Branch_ne   = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.CPU_MIO     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ExtZero     = 1'b0;
    bus.PCSource    = 2'b00;
    w_alu           = A_AND;
    if (!rst) begin
      unique case (r_state)
        S_IF: begin
          bus.MemRead = 1'b1;
          bus.CPU_MIO = 1'b1;
          bus.ALUSrcB = 2'b01;
          w_alu       = A_ADD;
          bus.IRWrite = w_ready;
          bus.PCWrite = w_ready;
        end
        S_ID: begin
          bus.ALUSrcB = 2'b11;
          w_alu       = A_ADD;
        end
        S_MA: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          w_alu       = A_ADD;
        end
        S_MR: begin
          bus.MemRead = 1'b1;
          bus.CPU_MIO = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_LWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MW: begin
          bus.MemWrite = 1'b1;
          bus.CPU_MIO  = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_REX: begin
          bus.ALUSrcA = 1'b1;
          unique case (bus.Fun)
            6'b100010: w_alu = A_SUB;
            6'b100100: w_alu = A_AND;
            6'b100101: w_alu = A_OR;
            6'b101010: w_alu = A_SLT;
            6'b100111: w_alu = A_NOR;
            6'b100110: w_alu = A_XOR;
            6'b000010: w_alu = A_SRL;
            default:   w_alu = A_ADD;
          endcase
        end
        S_RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_BR: begin
          bus.ALUSrcA     = 1'b1;
          w_alu           = A_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
          bus.Branch_ne   = bus.OPcode[0];
        end
        S_J: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        S_IEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          unique case (bus.OPcode)
            OP_SLTI: w_alu = A_SLT;
            OP_ANDI: begin
              w_alu       = A_AND;
              bus.ExtZero = 1'b1;
            end
            OP_ORI: begin
              w_alu       = A_OR;
              bus.ExtZero = 1'b1;
            end
            default: w_alu = A_ADD;
          endcase
        end
        S_IWB: bus.RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ALU_Control = ALU_CTRL_W'(w_alu);
  assign bus.bus_err     = r_bus_err & ~rst;
  assign bus.state       = rst ? 4'd0 : r_state;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_op  = ~rst & (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl (MEM_TIMEOUT=4).
// Directed scenarios plus a random instruction stream against a phase model.
module tb_multi_cycle_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl_if #(.ALU_CTRL_W(3)) bus ();

  multi_cycle_ctrl #(
    .ALU_CTRL_W (3),
    .MEM_TIMEOUT(TMO),
    .TMO_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    int st;
    bit rdy;
    bit tmo;
  } step_t;

  step_t q[$];
  bit    tmo_hit;

  localparam logic [2:0] A_AND = 3'b000, A_OR  = 3'b001, A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110, A_SLT = 3'b111, A_NOR = 3'b100;
  localparam logic [2:0] A_XOR = 3'b011, A_SRL = 3'b101;

  function automatic logic [2:0] fun_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return A_ADD;
      6'h22:   return A_SUB;
      6'h24:   return A_AND;
      6'h25:   return A_OR;
      6'h2a:   return A_SLT;
      6'h27:   return A_NOR;
      6'h26:   return A_XOR;
      6'h02:   return A_SRL;
      default: return A_ADD;
    endcase
  endfunction

  // Control word the spec table requires in a given state.
  function automatic logic [19:0] exp_word(input int st,
    input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    logic pcw, pcc, bne, iord, mr, mw, irw, cpu;
    logic m2r, rd, rw, sa, ez;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {pcw, pcc, bne, iord, mr, mw, irw, cpu} = '0;
    {m2r, rd, rw, sa, ez, sb, ps, alu} = '0;
    case (st)
      0:  begin mr = 1; cpu = 1; sb = 2'b01; alu = A_ADD;
                irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; alu = A_ADD; end
      2:  begin sa = 1; sb = 2'b10; alu = A_ADD; end
      3:  begin mr = 1; cpu = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; cpu = 1; iord = 1; end
      6:  begin sa = 1; alu = fun_alu(fn); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; alu = A_SUB; pcc = 1; ps = 2'b01;
                bne = op[0]; end
      9:  begin pcw = 1; ps = 2'b10; end
      10: begin
        sa = 1; sb = 2'b10;
        case (op)
          6'h0a:   alu = A_SLT;
          6'h0c:   begin alu = A_AND; ez = 1; end
          6'h0d:   begin alu = A_OR;  ez = 1; end
          default: alu = A_ADD;
        endcase
      end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, bne, iord, mr, mw, irw, cpu,
            m2r, rd, rw, sa, sb, ez, ps, alu};
  endfunction

  function automatic logic [19:0] dut_word();
    return {bus.PCWrite, bus.PCWriteCond, bus.Branch_ne, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite, bus.CPU_MIO,
            bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ExtZero, bus.PCSource, bus.ALU_Control};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      bus.OPcode    = 6'($urandom);
      bus.Fun       = 6'($urandom);
      bus.MIO_ready = 1'b1;
      #1;
      checks++;
      if (dut_word() !== 20'd0 || bus.state !== 4'd0
          || bus.bus_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_outs: word=%h state=%0d err=%b want 0",
                 dut_word(), bus.state, bus.bus_err);
      end
      next_cycle();
    end
    rst = 1'b0;
    bus.MIO_ready = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.MemRead !== 1'b1) begin
      errors++;
      $display("FAIL reset_exit: state=%0d MemRead=%b want 0/1",
               bus.state, bus.MemRead);
    end
    next_cycle();
  endtask

  task automatic test_add();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    do_reset();
    bus.OPcode = 6'h00; bus.Fun = 6'h20; bus.MIO_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.state !== 4'(exp_st[i])) begin
        errors++;
        $display("FAIL add_state[%0d]: got %0d want %0d",
                 i, bus.state, exp_st[i]);
      end
      checks++;
      if (bus.RegWrite !== (i == 3) || bus.RegDst !== (i == 3)) begin
        errors++;
        $display("FAIL add_wb[%0d]: RegWrite=%b RegDst=%b want %b",
                 i, bus.RegWrite, bus.RegDst, (i == 3));
      end
      next_cycle();
    end
  endtask

  task automatic test_lw_wait();
    bit rdy[9]    = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
    int exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    int n_mr = 0;
    int n_wb = 0;
    do_reset();
    bus.OPcode = 6'h23; bus.Fun = 6'h00;
    for (int i = 0; i < 9; i++) begin
      bus.MIO_ready = rdy[i];
      #1;
      if (bus.state === 4'd3) n_mr++;
      if (bus.RegWrite === 1'b1 && bus.MemtoReg === 1'b1) n_wb++;
      checks++;
      if (bus.state !== 4'(exp_st[i])) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %0d want %0d",
                 i, bus.state, exp_st[i]);
      end
      next_cycle();
    end
    checks++;
    if (n_mr != 4) begin
      errors++;
      $display("FAIL lw_mr_cycles: got %0d want 4", n_mr);
    end
    checks++;
    if (n_wb != 1) begin
      errors++;
      $display("FAIL lw_wb_count: got %0d want 1", n_wb);
    end
    checks++;
    if (bus.bus_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus_err: got %b want 0", bus.bus_err);
    end
  endtask

  task automatic test_bne();
    logic [5:0] ops[2] = '{6'h05, 6'h04};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      bus.OPcode = ops[k]; bus.Fun = 6'($urandom); bus.MIO_ready = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      checks++;
      if (bus.state !== 4'd8 || bus.PCWriteCond !== 1'b1
          || bus.Branch_ne !== ops[k][0] || bus.PCSource !== 2'b01
          || bus.ALU_Control !== 3'b110) begin
        errors++;
        $display("FAIL br_%0d: st=%0d pcc=%b bne=%b ps=%b alu=%b want 8/1/%b/01/110",
                 ops[k], bus.state, bus.PCWriteCond, bus.Branch_ne,
                 bus.PCSource, bus.ALU_Control, ops[k][0]);
      end
      next_cycle();
      #1;
      checks++;
      if (bus.state !== 4'd0) begin
        errors++;
        $display("FAIL br_return: got %0d want 0", bus.state);
      end
      next_cycle();
    end
  endtask

  task automatic test_sw_timeout();
    bit rdy[9]    = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    int exp_st[9] = '{0, 1, 2, 5, 5, 5, 5, 0, 0};
    do_reset();
    bus.OPcode = 6'h2b; bus.Fun = 6'h00;
    for (int i = 0; i < 9; i++) begin
      bus.MIO_ready = rdy[i];
      #1;
      checks++;
      if (bus.state !== 4'(exp_st[i])
          || bus.MemWrite !== (exp_st[i] == 5)
          || bus.bus_err !== (i >= 7)) begin
        errors++;
        $display("FAIL sw_tmo[%0d]: st=%0d mw=%b err=%b want %0d/%b/%b",
                 i, bus.state, bus.MemWrite, bus.bus_err, exp_st[i],
                 (exp_st[i] == 5), (i >= 7));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.OPcode = 6'h23; bus.Fun = 6'h00; bus.MIO_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    bus.MIO_ready = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd3) begin
      errors++;
      $display("FAIL rmid_pre: got %0d want 3", bus.state);
    end
    next_cycle();
    rst = 1'b1;
    bus.MIO_ready = 1'b1;
    #1;
    checks++;
    if (dut_word() !== 20'd0 || bus.state !== 4'd0) begin
      errors++;
      $display("FAIL rmid_outs: word=%h state=%0d want 0",
               dut_word(), bus.state);
    end
    next_cycle();
    rst = 1'b0;
    bus.MIO_ready = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after: state=%0d RegWrite=%b want 0/0",
               bus.state, bus.RegWrite);
    end
    next_cycle();
  endtask

  task automatic test_illegal();
    do_reset();
    bus.OPcode = 6'h3f; bus.Fun = 6'h00; bus.MIO_ready = 1'b1;
    next_cycle();
    next_cycle();
`ifdef MCTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.state !== 4'd12 || bus.illegal_op !== 1'b1
          || dut_word() !== 20'd0) begin
        errors++;
        $display("FAIL trap[%0d]: st=%0d ill=%b word=%h want 12/1/0",
                 i, bus.state, bus.illegal_op, dut_word());
      end
      next_cycle();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL trap_rst: ill=%b want 0", bus.illegal_op);
    end
    next_cycle();
    rst = 1'b0;
`else
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL illegal_nop: got %0d want 0", bus.state);
    end
    next_cycle();
    #1;
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL illegal_next: got %0d want 1", bus.state);
    end
    next_cycle();
`endif
  endtask

  function automatic int pick_waits();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(TMO, TMO + 2));
    return int'($urandom_range(0, TMO - 1));
  endfunction

  task automatic add_mem(input int st, input int waits);
    if (waits >= TMO) begin
      for (int i = 0; i < TMO; i++)
        q.push_back('{st, 1'b0, (i == TMO - 1)});
      tmo_hit = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) q.push_back('{st, 1'b0, 1'b0});
      q.push_back('{st, 1'b1, 1'b0});
    end
  endtask

  task automatic add_st(input int st);
    q.push_back('{st, 1'($urandom), 1'b0});
  endtask

  task automatic test_random();
    logic [5:0] ops[12] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                            6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h3f, 6'h11};
    logic [5:0] funs[8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                            6'h2a, 6'h27, 6'h26, 6'h02};
    bit exp_err = 1'b0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    int n_ops = 10;
`else
    int n_ops = 12;
`endif
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int fi;
      op = ops[$urandom_range(0, n_ops - 1)];
      fi = int'($urandom_range(0, 8));
      fn = (fi == 8) ? 6'($urandom) : funs[fi];
      q.delete();
      tmo_hit = 1'b0;
      add_mem(0, pick_waits());
      if (!tmo_hit) begin
        add_st(1);
        case (op)
          6'h00: begin add_st(6); add_st(7); end
          6'h23: begin
            add_st(2);
            add_mem(3, pick_waits());
            if (!tmo_hit) add_st(4);
          end
          6'h2b: begin add_st(2); add_mem(5, pick_waits()); end
          6'h04, 6'h05: add_st(8);
          6'h02: add_st(9);
          6'h08, 6'h0a, 6'h0c, 6'h0d: begin add_st(10); add_st(11); end
          default: ;
        endcase
      end
      foreach (q[i]) begin
        bus.OPcode = op; bus.Fun = fn; bus.MIO_ready = q[i].rdy;
        #1;
        checks++;
        if (bus.state !== 4'(q[i].st)) begin
          errors++;
          $display("FAIL rnd_state n=%0d op=%h: got %0d want %0d",
                   n, op, bus.state, q[i].st);
        end
        checks++;
        if (dut_word() !== exp_word(q[i].st, op, fn, q[i].rdy)
            || bus.bus_err !== exp_err) begin
          errors++;
          $display("FAIL rnd_ctrl n=%0d st=%0d: word=%h err=%b want %h/%b",
                   n, q[i].st, dut_word(), bus.bus_err,
                   exp_word(q[i].st, op, fn, q[i].rdy), exp_err);
        end
        if (q[i].tmo) exp_err = 1'b1;
        next_cycle();
      end
    end
  endtask

  initial begin
    bus.OPcode = '0; bus.Fun = '0; bus.MIO_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_lw_wait();
    test_bne();
    test_sw_timeout();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
